// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg
//   Shared definitions for the CPU instruction sequencer:
//   opcode encodings, CPU control encodings (opsel/outsel), the
//   sequencer FSM state type and the decoded instruction record.
//   The HALT state exists only when SEQ_OVF_TRAP_EN is defined.
package cpu_seq_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_READ  = 3'b100;

    // opsel: ALU operation select. STORE and READ also use the 01 encoding.
    localparam logic [1:0] OPSEL_ADD = 2'b00;
    localparam logic [1:0] OPSEL_SUB = 2'b01;

    // outsel: 00 routes the direct path, 01 routes the ALU result.
    localparam logic [1:0] OUTSEL_DIRECT = 2'b00;
    localparam logic [1:0] OUTSEL_ALU    = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_EXEC,
        ST_CAPTURE
`ifdef SEQ_OVF_TRAP_EN
        , ST_HALT
`endif
    } state_t;

    // Instruction as held by the sequencer; the three ignored bits of the
    // raw 48-bit word are dropped before buffering.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [4:0]  addra;
        logic [4:0]  addrb;
        logic [31:0] imm;
    } instr_t;

    localparam int unsigned INSTR_W = $bits(instr_t);

    function automatic logic is_illegal(input logic [2:0] op);
        return op[2] & (|op[1:0]);
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// seq_fifo
//   Synchronous FIFO, power-of-two DEPTH, first-word-fall-through read
//   (dout always shows the head entry while not empty).
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset (empties FIFO)
//     push, din      write request / data (ignored when full unless popping)
//     pop, dout      read request / head data (ignored when empty)
//     full, empty    status
module seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Buffers 48-bit instructions and sequences them onto a simple CPU
//   datapath, capturing the CPU result for ADD/SUB/READ.
//   Optional feature: define SEQ_OVF_TRAP_EN to halt after an overflowing
//   result until halt_clr.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     in_valid, in_ready, in_instr    instruction push handshake
//       in_instr: [47:45] opcode, [44:40] addrA, [39:35] addrB, [31:0] imm
//     addressA, addressB, dataIn,
//     asel, bsel, opsel, outsel, oen  CPU control outputs
//     outPut, over                    CPU result and overflow
//     res_data, res_valid, res_ovf    captured result (res_valid 1-cycle pulse)
//     ovf_sticky, halt_clr            sticky overflow flag and its clear
//     illegal                         1-cycle pulse on an illegal opcode
//     busy                            sequencer active or FIFO non-empty
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_instr,
    output logic [4:0]  addressA,
    output logic [4:0]  addressB,
    output logic [31:0] dataIn,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  opsel,
    output logic [1:0]  outsel,
    output logic        oen,
    input  logic [31:0] outPut,
    input  logic        over,
    output logic [31:0] res_data,
    output logic        res_valid,
    output logic        res_ovf,
    output logic        ovf_sticky,
    output logic        illegal,
    output logic        busy,
    input  logic        halt_clr
);

    state_t state;
    state_t state_nx;
    instr_t in_dec;
    instr_t fifo_head;
    instr_t hold;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;
    logic   active;
    logic   cap_ovf;
    logic   unused_bits;

    assign in_dec      = '{opcode: in_instr[47:45], addra: in_instr[44:40],
                           addrb: in_instr[39:35], imm: in_instr[31:0]};
    assign unused_bits = ^in_instr[34:32];

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign busy     = (state != ST_IDLE) || !fifo_empty;
    assign active   = (state == ST_ISSUE) || (state == ST_EXEC) || (state == ST_CAPTURE);
    // READ never reports overflow.
    assign cap_ovf  = over && (hold.opcode != OP_READ);
    assign illegal  = (state == ST_ISSUE) && is_illegal(hold.opcode);

    seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_dec),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold       <= '0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            res_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            state     <= state_nx;
            res_valid <= 1'b0;
            if (pop) begin
                hold <= fifo_head;
            end
            if (state == ST_CAPTURE) begin
                res_data  <= outPut;
                res_ovf   <= cap_ovf;
                res_valid <= 1'b1;
            end
            // A capture with overflow wins over a simultaneous clear.
            if (state == ST_CAPTURE && cap_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (halt_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (hold.opcode)
                    OP_ADD, OP_SUB: state_nx = ST_EXEC;
                    OP_READ:        state_nx = ST_CAPTURE;
                    default:        state_nx = ST_IDLE;
                endcase
            end
            ST_EXEC: state_nx = ST_CAPTURE;
            ST_CAPTURE: begin
`ifdef SEQ_OVF_TRAP_EN
                state_nx = cap_ovf ? ST_HALT : ST_IDLE;
`else
                state_nx = ST_IDLE;
`endif
            end
`ifdef SEQ_OVF_TRAP_EN
            ST_HALT: begin
                if (halt_clr) begin
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        addressA = '0;
        addressB = '0;
        dataIn   = '0;
        asel     = 1'b1;
        bsel     = 1'b1;
        opsel    = OPSEL_ADD;
        outsel   = OUTSEL_DIRECT;
        oen      = 1'b0;
        if (active) begin
            case (hold.opcode)
                OP_STORE: begin
                    oen      = 1'b1;
                    asel     = 1'b0;
                    bsel     = 1'b0;
                    opsel    = OPSEL_SUB;
                    outsel   = OUTSEL_DIRECT;
                    dataIn   = hold.imm;
                    addressA = hold.addra;
                    addressB = hold.addrb;
                end
                OP_ADD, OP_SUB: begin
                    oen      = 1'b1;
                    opsel    = (hold.opcode == OP_SUB) ? OPSEL_SUB : OPSEL_ADD;
                    outsel   = OUTSEL_ALU;
                    addressA = hold.addra;
                    addressB = hold.addrb;
                end
                OP_READ: begin
                    oen      = 1'b1;
                    bsel     = 1'b0;
                    opsel    = OPSEL_SUB;
                    addressA = hold.addra;
                    addressB = hold.addra;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    localparam logic [2:0] T_NOP   = 3'b000;
    localparam logic [2:0] T_STORE = 3'b001;
    localparam logic [2:0] T_ADD   = 3'b010;
    localparam logic [2:0] T_SUB   = 3'b011;
    localparam logic [2:0] T_READ  = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_instr;
    logic [4:0]  addressA;
    logic [4:0]  addressB;
    logic [31:0] dataIn;
    logic        asel;
    logic        bsel;
    logic [1:0]  opsel;
    logic [1:0]  outsel;
    logic        oen;
    logic [31:0] outPut;
    logic        over;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ovf;
    logic        ovf_sticky;
    logic        illegal;
    logic        busy;
    logic        halt_clr;
    logic [49:0] ctl_now;

    cpu_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .addressA   (addressA),
        .addressB   (addressB),
        .dataIn     (dataIn),
        .asel       (asel),
        .bsel       (bsel),
        .opsel      (opsel),
        .outsel     (outsel),
        .oen        (oen),
        .outPut     (outPut),
        .over       (over),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ovf    (res_ovf),
        .ovf_sticky (ovf_sticky),
        .illegal    (illegal),
        .busy       (busy),
        .halt_clr   (halt_clr)
    );

    always #5 clk = ~clk;

    assign ctl_now = {addressA, addressB, dataIn, asel, bsel, opsel, outsel, oen, illegal};

    typedef struct {
        logic [47:0] instr;
        logic [31:0] res;
        logic        ovf;
        logic [49:0] ctl;
        int          lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          rv_cnt = 0;
    int          ill_cnt = 0;
    logic [32:0] sb_q[$];
    vec_t        vecs[8];

    function automatic logic [47:0] mkins(input logic [2:0] op, input logic [4:0] a,
                                          input logic [4:0] b, input logic [31:0] imm);
        return {op, a, b, 3'b111, imm};
    endfunction

    function automatic logic [49:0] mkctl(input logic [4:0] a, input logic [4:0] b,
                                          input logic [31:0] din, input logic as, input logic bs,
                                          input logic [1:0] ops, input logic [1:0] outs,
                                          input logic oe, input logic ill);
        return {a, b, din, as, bs, ops, outs, oe, ill};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and service the result scoreboard.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        if (res_valid) begin
            rv_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_res_valid actual=res_valid=1 expected=no result pending");
            end else begin
                e = sb_q.pop_front();
                chk("res_ovf_data", 64'({res_ovf, res_data}), 64'(e));
            end
        end
        if (illegal) begin
            ill_cnt++;
            chk("illegal_oen", 64'(oen), 64'(0));
        end
    endtask

    task automatic push_instr(input logic [47:0] ins);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=in_ready=0 expected=1 within 50 cycles");
        end
        in_valid = 1'b1;
        in_instr = ins;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   seen = 0;
        logic eovf;
        outPut = v.res;
        over   = v.ovf;
        eovf   = (v.instr[47:45] == T_READ) ? 1'b0 : v.ovf;
        if (v.lat != 0) begin
            sb_q.push_back({eovf, v.res});
        end
        push_instr(v.instr);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                chk("ctl_issue", 64'(ctl_now), 64'(v.ctl));
            end
            if (c == 2 && v.lat == 4) begin
                chk("ctl_exec", 64'(ctl_now), 64'(v.ctl));
            end
            if (res_valid && seen == 0) begin
                seen = c;
            end
        end
        chk("latency", 64'(seen), 64'(v.lat));
        chk("busy_done", 64'(busy), 64'(0));
    endtask

    initial begin
        int rv_before;
        int ill_before;
        int n;

        vecs[0] = '{mkins(T_STORE, 5'd3, 5'd0, 32'hFFFF_FFE7), 32'h0, 1'b0,
                    mkctl(5'd3, 5'd0, 32'hFFFF_FFE7, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0), 0};
        vecs[1] = '{mkins(T_ADD, 5'd0, 5'd1, 32'h0000_1111), 32'hFFFF_FFF6, 1'b0,
                    mkctl(5'd0, 5'd1, 32'h0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0), 4};
        vecs[2] = '{mkins(T_SUB, 5'd2, 5'd20, 32'h0), 32'hFFFF_FFEC, 1'b0,
                    mkctl(5'd2, 5'd20, 32'h0, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0), 4};
        vecs[3] = '{mkins(T_READ, 5'd7, 5'd9, 32'hDEAD_BEEF), 32'h1234_5678, 1'b1,
                    mkctl(5'd7, 5'd7, 32'h0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0), 3};
        vecs[4] = '{mkins(T_NOP, 5'd5, 5'd6, 32'h0000_1234), 32'h0, 1'b0,
                    mkctl(5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0), 0};
        vecs[5] = '{mkins(3'b111, 5'd31, 5'd31, 32'hFFFF_FFFF), 32'h0, 1'b0,
                    mkctl(5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1), 0};
        vecs[6] = '{mkins(3'b101, 5'd9, 5'd10, 32'h5555_AAAA), 32'h0, 1'b0,
                    mkctl(5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1), 0};
        vecs[7] = '{mkins(T_ADD, 5'd31, 5'd30, 32'hFFFF_FFFF), 32'h7FFF_FFFF, 1'b0,
                    mkctl(5'd31, 5'd30, 32'h0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0), 4};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        outPut   = '0;
        over     = 1'b0;
        halt_clr = 1'b0;

        #2;
        chk("reset_ctl", 64'(ctl_now),
            64'(mkctl(5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0)));
        chk("reset_status", 64'({res_valid, res_data, res_ovf, ovf_sticky, busy}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", 64'(in_ready), 64'(1));

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end
        chk("sticky_after_read", 64'(ovf_sticky), 64'(0));

        // Back-to-back pushes while the first ADD executes fill the FIFO.
        ill_before = ill_cnt;
        outPut = 32'hA5A5_0001;
        over   = 1'b0;
        sb_q.push_back({1'b0, 32'hA5A5_0001});
        sb_q.push_back({1'b0, 32'hA5A5_0001});
        sb_q.push_back({1'b0, 32'hA5A5_0001});
        push_instr(mkins(T_ADD, 5'd0, 5'd1, 32'h0));
        push_instr(mkins(T_ADD, 5'd2, 5'd3, 32'h0));
        push_instr(mkins(3'b111, 5'd4, 5'd4, 32'h0));
        push_instr(mkins(T_READ, 5'd4, 5'd0, 32'h0));
        push_instr(mkins(T_STORE, 5'd6, 5'd7, 32'h0000_00AB));
        chk("in_ready_full", 64'(in_ready), 64'(0));
        chk("busy_full", 64'(busy), 64'(1));
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("drain_busy", 64'(busy), 64'(0));
        chk("illegal_pulses", 64'(ill_cnt - ill_before), 64'(1));
        chk("in_ready_drained", 64'(in_ready), 64'(1));

        // Overflowing ADD sets the sticky flag; halt_clr clears it.
        outPut = 32'h8000_0000;
        over   = 1'b1;
        sb_q.push_back({1'b1, 32'h8000_0000});
        push_instr(mkins(T_ADD, 5'd5, 5'd6, 32'h0));
        repeat (4) tick();
        chk("ovf_sticky_set", 64'(ovf_sticky), 64'(1));
        over = 1'b0;
`ifdef SEQ_OVF_TRAP_EN
        push_instr(mkins(T_STORE, 5'd1, 5'd2, 32'h0000_0042));
        repeat (3) tick();
        chk("halt_holds", 64'({busy, oen}), 64'(2'b10));
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        repeat (4) tick();
        chk("halt_released", 64'(busy), 64'(0));
`else
        repeat (2) tick();
        chk("no_halt", 64'(busy), 64'(0));
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
`endif
        chk("sticky_cleared", 64'(ovf_sticky), 64'(0));

        // Asynchronous reset in EXEC abandons the instruction.
        outPut = 32'h0BAD_0BAD;
        push_instr(mkins(T_ADD, 5'd8, 5'd9, 32'h0));
        tick();
        tick();
        chk("exec_oen", 64'(oen), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", 64'(ctl_now),
            64'(mkctl(5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0)));
        chk("async_reset_status", 64'({res_valid, busy, in_ready, res_ovf, ovf_sticky}),
            64'(5'b00100));
        tick();
        rst_n = 1'b1;
        rv_before = rv_cnt;
        repeat (6) tick();
        chk("no_res_after_reset", 64'(rv_cnt), 64'(rv_before));
        chk("idle_after_reset", 64'(busy), 64'(0));

        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
